dmem_ctrl: RTL

DMEM_CTRL -- requirements
Module: dmem_ctrl

---
 rtl/dmem_ctrl.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/dmem_ctrl.sv
// Data-memory controller: fixed-latency byte/half/word loads and stores with pipeline stall.
// Defining DMEM_MISALIGN_TRAP_EN turns misaligned H/W accesses into a trap pulse instead of forced alignment.
module dmem_ctrl #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        rst,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [31:0] ALU_ResultM,
  input  logic [31:0] WriteDataM,
  input  logic [2:0]  funct3M,
  output logic [31:0] RD,
  output logic        StallM,
  output logic        MisalignM
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   addr_q, wdata_q, rd_q;
  logic [2:0]    funct3_q;
  logic          store_q;

  logic          req, capture, access;
  logic [31:0]   acc_addr, acc_wdata;
  logic [2:0]    acc_funct3;
  logic          acc_store;
  logic          is_byte, is_half, misaligned, trap;
  logic [1:0]    lane;
  logic [AW-1:0] idx;
  logic [3:0]    be;
  logic [31:0]   wlanes, word, ld_data;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic          unused_addr_hi;

  logic [31:0]   mem_q [DEPTH_WORDS];

  assign req = MemReadM | MemWriteM;

  // Next-state, stall and access-strobe logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    StallM  = 1'b0;
    capture = 1'b0;
    access  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          StallM  = 1'b1;
          capture = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_d = DONE;
            access  = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CW'(WAIT_CYCLES);
          end
        end
      end
      WAIT: begin
        StallM = 1'b1;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
          access  = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Zero-latency builds access straight from the pipeline; otherwise from the captured request
  always_comb begin
    if (state_q == IDLE) begin
      acc_addr   = ALU_ResultM;
      acc_wdata  = WriteDataM;
      acc_funct3 = funct3M;
      acc_store  = MemWriteM;
    end else begin
      acc_addr   = addr_q;
      acc_wdata  = wdata_q;
      acc_funct3 = funct3_q;
      acc_store  = store_q;
    end
  end

  // Reserved size encodings fall through to word
  assign is_byte    = (acc_funct3[1:0] == 2'b00);
  assign is_half    = (acc_funct3[1:0] == 2'b01);
  assign misaligned = (is_half && acc_addr[0]) ||
                      (!is_byte && !is_half && (acc_addr[1:0] != 2'b00));
  assign lane       = is_byte ? acc_addr[1:0] :
                      is_half ? {acc_addr[1], 1'b0} : 2'b00;
  assign idx        = acc_addr[AW+1:2];
  assign unused_addr_hi = ^acc_addr[31:AW+2];

  always_comb begin
    be     = 4'b1111;
    wlanes = acc_wdata;
    if (is_byte) begin
      be     = 4'b0001 << lane;
      wlanes = {4{acc_wdata[7:0]}};
    end else if (is_half) begin
      be     = 4'b0011 << lane;
      wlanes = {2{acc_wdata[15:0]}};
    end
  end

  assign word    = mem_q[idx];
  assign ld_byte = word[{lane, 3'b000} +: 8];
  assign ld_half = word[{lane[1], 4'b0000} +: 16];

  always_comb begin
    ld_data = word;
    if (is_byte) begin
      ld_data = acc_funct3[2] ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
    end else if (is_half) begin
      ld_data = acc_funct3[2] ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
    end
  end

  // Memory array is never reset; a reset edge suppresses any pending write
  always_ff @(posedge CLK) begin
    if (rst && access && acc_store && !trap) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_q[idx][8*b +: 8] <= wlanes[8*b +: 8];
      end
    end
  end

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      funct3_q <= '0;
      store_q  <= 1'b0;
      rd_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        addr_q   <= ALU_ResultM;
        wdata_q  <= WriteDataM;
        funct3_q <= funct3M;
        store_q  <= MemWriteM;
      end
      if (access && !acc_store && !trap) rd_q <= ld_data;
    end
  end

  assign RD = rd_q;

`ifdef DMEM_MISALIGN_TRAP_EN
  logic mis_q;

  assign trap = misaligned;

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) mis_q <= 1'b0;
    else      mis_q <= access & misaligned;
  end

  assign MisalignM = mis_q;
`else
  logic unused_misaligned;

  assign trap              = 1'b0;
  assign unused_misaligned = misaligned;
  assign MisalignM         = 1'b0;
`endif

endmodule
